checksum_core: RTL and testbench



---
 rtl/checksum_pkg.sv | 12 +
 rtl/checksum_smul.sv | 48 ++++
 rtl/checksum_core.sv | 59 +++++
 tb/tb_checksum_core.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared width constants for the sign-magnitude multiply stage.
package checksum_pkg;

   localparam int CK_IN_W    = 17;
   localparam int CK_POLY_W  = 17;
   localparam int CK_SUM_W   = CK_IN_W + CK_POLY_W;
   localparam int CK_MAG_W   = CK_POLY_W - 1;
   localparam int CK_SIGN_IX = CK_POLY_W - 1;

   typedef logic [CK_SUM_W-1:0] ck_sum_t;

endpackage

// File: rtl/checksum_smul.sv
// Registered sign-magnitude multiplier: magnitude * data, then conditional two's-complement negate.
module checksum_smul
   import checksum_pkg::*;
#(
   parameter int IN_DATA_WIDTH = CK_IN_W,
   parameter int POLY_WIDTH    = CK_POLY_W,
   parameter int SUM_WIDTH     = CK_SUM_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     prod_en_i,
   input  logic                     result_en_i,
   input  logic [IN_DATA_WIDTH-1:0] data_i,
   input  logic [POLY_WIDTH-1:0]    poly_i,
   output logic [SUM_WIDTH-1:0]     result_o
);

   localparam int MAG_WIDTH = POLY_WIDTH - 1;

   logic [SUM_WIDTH-1:0] prod_d, prod_q;
   logic [SUM_WIDTH-1:0] result_d, result_q;
   logic                 sign_q;

   always_comb begin
      prod_d   = SUM_WIDTH'(poly_i[MAG_WIDTH-1:0]) * SUM_WIDTH'(data_i);
      // Negative zero negates to zero, so no special case is needed.
      result_d = sign_q ? (~prod_q + SUM_WIDTH'(1)) : prod_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prod_q   <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         if (prod_en_i) begin
            prod_q <= prod_d;
            sign_q <= poly_i[POLY_WIDTH-1];
         end
         if (result_en_i) begin
            result_q <= result_d;
         end
      end
   end

   assign result_o = result_q;

endmodule

// File: rtl/checksum_core.sv
// Two-cycle-latency sign-magnitude multiply stage with a valid pipeline and no backpressure.
module checksum_core
   import checksum_pkg::*;
#(
   parameter int IN_DATA_WIDTH = CK_IN_W,
   parameter int POLY_WIDTH    = CK_POLY_W,
   parameter int SUM_WIDTH     = CK_SUM_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_data_vld,
   input  logic [IN_DATA_WIDTH-1:0] in_data,
   input  logic [POLY_WIDTH-1:0]    polynomial,
   output logic [SUM_WIDTH-1:0]     out_data,
   output logic                     out_data_vld
);

   logic [IN_DATA_WIDTH-1:0] data_q;
   logic [POLY_WIDTH-1:0]    poly_q;
   logic                     in_vld_q;
   logic                     prod_vld_q;
   logic                     out_vld_q;

   // Operand registers only load on valid beats so idle cycles leave the datapath untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q     <= '0;
         poly_q     <= '0;
         in_vld_q   <= 1'b0;
         prod_vld_q <= 1'b0;
         out_vld_q  <= 1'b0;
      end else begin
         if (in_data_vld) begin
            data_q <= in_data;
            poly_q <= polynomial;
         end
         in_vld_q   <= in_data_vld;
         prod_vld_q <= in_vld_q;
         out_vld_q  <= prod_vld_q;
      end
   end

   checksum_smul #(
      .IN_DATA_WIDTH (IN_DATA_WIDTH),
      .POLY_WIDTH    (POLY_WIDTH),
      .SUM_WIDTH     (SUM_WIDTH)
   ) u_smul (
      .clk         (clk),
      .reset       (reset),
      .prod_en_i   (in_vld_q),
      .result_en_i (prod_vld_q),
      .data_i      (data_q),
      .poly_i      (poly_q),
      .result_o    (out_data)
   );

   assign out_data_vld = out_vld_q;

endmodule

// File: tb/tb_checksum_core.sv
// Directed self-checking bench for checksum_core.
module tb_checksum_core;

   logic        clk;
   logic        reset;
   logic        in_data_vld;
   logic [16:0] in_data;
   logic [16:0] polynomial;
   logic [33:0] out_data;
   logic        out_data_vld;

   int checks = 0;
   int errors = 0;

   checksum_core dut (
      .clk          (clk),
      .reset        (reset),
      .in_data_vld  (in_data_vld),
      .in_data      (in_data),
      .polynomial   (polynomial),
      .out_data     (out_data),
      .out_data_vld (out_data_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [33:0] ref_model(input logic [16:0] d, input logic [16:0] p);
      logic [33:0] prod;
      prod = {18'b0, p[15:0]} * {17'b0, d};
      return p[16] ? (~prod + 34'd1) : prod;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (out_data_vld !== 1'b0 || out_data !== 34'd0) begin
         errors++;
         $display("FAIL %s: vld=%b data=%0d, required vld=0 data=0", name, out_data_vld, out_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_data = 17'd1234;
      polynomial = 17'd777;
      for (int c = 0; c < 10; c++) begin
         in_data_vld = c[0];
         step();
         check_idle("reset_hold");
      end
      in_data_vld = 1'b0;
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         check_idle("reset_release");
      end
   endtask

   task automatic test_single(input string name, input logic [16:0] d, input logic [16:0] p,
                              input logic [33:0] exp);
      in_data = d;
      polynomial = p;
      in_data_vld = 1'b1;
      step();
      in_data_vld = 1'b0;
      in_data = 17'h0;
      polynomial = 17'h0;
      step();
      checks++;
      if (out_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL %s_early_vld: vld=%b, required 0", name, out_data_vld);
      end
      step();
      checks++;
      if (out_data_vld !== 1'b1 || out_data !== exp) begin
         errors++;
         $display("FAIL %s_result: vld=%b data=%0d, required vld=1 data=%0d",
                  name, out_data_vld, out_data, exp);
      end
      step();
      checks++;
      if (out_data_vld !== 1'b0 || out_data !== exp) begin
         errors++;
         $display("FAIL %s_after: vld=%b data=%0d, required vld=0 data held %0d",
                  name, out_data_vld, out_data, exp);
      end
   endtask

   task automatic test_stream(input string name, input int stride);
      localparam int K = 10;
      logic [16:0] dv [K];
      logic [16:0] pv [K];
      int          b;
      for (int k = 0; k < K; k++) begin
         dv[k] = 17'(131071 - k * 4099);
         pv[k] = 17'(131071 - k * 9001);
      end
      for (int t = 0; t < stride * K + 3; t++) begin
         if (t % stride == 0 && t / stride < K) begin
            in_data_vld = 1'b1;
            in_data = dv[t / stride];
            polynomial = pv[t / stride];
         end else begin
            in_data_vld = 1'b0;
         end
         step();
         b = t - 2;
         checks++;
         if (b >= 0 && b % stride == 0 && b / stride < K) begin
            if (out_data_vld !== 1'b1 || out_data !== ref_model(dv[b / stride], pv[b / stride])) begin
               errors++;
               $display("FAIL %s_beat%0d: vld=%b data=%0d, required vld=1 data=%0d", name,
                        b / stride, out_data_vld, out_data, ref_model(dv[b / stride], pv[b / stride]));
            end
         end else if (out_data_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap_t%0d: vld=%b, required 0", name, t, out_data_vld);
         end
      end
      in_data_vld = 1'b0;
   endtask

   task automatic test_reset_flush();
      in_data_vld = 1'b1;
      in_data = 17'd100;
      polynomial = 17'd300;
      step();
      in_data = 17'd200;
      polynomial = 17'd65536 + 17'd400;
      step();
      in_data_vld = 1'b0;
      reset = 1'b0;
      step();
      check_idle("flush_in_reset");
      reset = 1'b1;
      in_data_vld = 1'b1;
      in_data = 17'd7;
      polynomial = 17'd65536 + 17'd9;
      step();
      in_data_vld = 1'b0;
      check_idle("flush_drop_a");
      step();
      check_idle("flush_drop_b");
      step();
      checks++;
      if (out_data_vld !== 1'b1 || out_data !== 34'h3_FFFF_FFC1) begin
         errors++;
         $display("FAIL flush_next_beat: vld=%b data=%0d, required vld=1 data=%0d",
                  out_data_vld, out_data, 34'h3_FFFF_FFC1);
      end
      step();
      checks++;
      if (out_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL flush_next_after: vld=%b, required 0", out_data_vld);
      end
   endtask

   initial begin
      reset = 1'b0;
      in_data_vld = 1'b0;
      in_data = '0;
      polynomial = '0;
      test_reset();
      test_single("pos_small", 17'd2, 17'd65535, 34'd131070);
      test_single("neg_max", 17'd131071, 17'd131071, 34'd8590131199);
      test_single("neg_zero", 17'd5, 17'd65536, 34'd0);
      test_stream("back_to_back", 1);
      test_stream("every_other", 2);
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
